note_lane_renderer: RTL and testbench

- Pixel-domain colour stage directly downstream of the horizontal/vertical timing generators.
- Consumes x_crd, y_crd, blank and vsync. Keeps four scrolling note lanes, where each lane is a 16-slot occupancy shift register.
- Scores button hits against the bottom slot and drives registered 12-bit RGB to the VGA DAC pins.
- Timing is the 800x600 frame: 1040 pixels per line, 666 lines per frame.

---
 rtl/note_lane_renderer.sv | 154 +++++++++++++++
 tb/tb_note_lane_renderer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/note_lane_renderer.sv
// Four-lane scrolling note renderer for the 800x600 pixel pipeline: lane occupancy
// shift registers, button hit/miss scoring and registered 12-bit RGB output.
module note_lane_renderer #(
    parameter int unsigned SCROLL_DIV = 4,
    parameter int unsigned LANE_X0    = 200,
    parameter int unsigned LANE_W     = 100,
    parameter int unsigned SLOT_H     = 32,
    parameter int unsigned HITBAR_Y   = 544
) (
    input  logic        pixel_clk,
    input  logic        rst,
    input  logic [10:0] x_crd,
    input  logic [10:0] y_crd,
    input  logic        blank_in,
    input  logic        vsync_in,
    input  logic        note_valid,
    input  logic [1:0]  note_lane,
    input  logic [3:0]  btn,
    output logic [11:0] rgb,
    output logic [15:0] score,
    output logic [15:0] miss_cnt,
    output logic        scroll_tick
);

    localparam int unsigned SLOT_SHIFT = $clog2(SLOT_H);
    localparam logic [10:0] X0         = 11'(LANE_X0);
    localparam logic [10:0] X1         = 11'(LANE_X0 + LANE_W);
    localparam logic [10:0] X2         = 11'(LANE_X0 + 2 * LANE_W);
    localparam logic [10:0] X3         = 11'(LANE_X0 + 3 * LANE_W);
    localparam logic [10:0] X4         = 11'(LANE_X0 + 4 * LANE_W);
    localparam logic [10:0] NOTE_Y_END = 11'(16 * SLOT_H);
    localparam logic [10:0] HB_Y0      = 11'(HITBAR_Y);
    localparam logic [10:0] HB_Y1      = 11'(HITBAR_Y + 16);
    localparam logic [3:0]  DIV_LAST   = 4'(SCROLL_DIV - 1);

    logic             vsync_q;
    logic [3:0]       frame_cnt;
    logic [3:0][15:0] lane;
    logic [3:0][15:0] lane_nxt;
    logic [3:0]       pending;
    logic [3:0]       pending_nxt;
    logic [3:0]       btn_s1;
    logic [3:0]       btn_s2;
    logic [3:0]       btn_prev;

    logic       frame_start;
    logic       shift;
    logic [3:0] slot0;
    logic [3:0] hit_req;
    logic [3:0] hit;
    logic [3:0] miss;
    logic [3:0] note_req;

    function automatic logic [2:0] popcnt4(input logic [3:0] v);
        popcnt4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [2:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {14'b0, b};
        sat_add = s[16] ? '1 : s[15:0];
    endfunction

    function automatic logic [11:0] lane_colour(input logic [1:0] l);
        case (l)
            2'd0:    lane_colour = 12'h0F0;
            2'd1:    lane_colour = 12'hF00;
            2'd2:    lane_colour = 12'hFF0;
            default: lane_colour = 12'h00F;
        endcase
    endfunction

    always_comb begin
        frame_start = vsync_q & ~vsync_in;
        shift       = frame_start && (frame_cnt == DIV_LAST);
        for (int unsigned l = 0; l < 4; l++) slot0[l] = lane[l][0];
        hit_req  = btn_s2 & ~btn_prev;
        // Hits are judged on the pre-shift bottom slot, so a hit note never also counts as a miss.
        hit      = hit_req & slot0;
        miss     = shift ? (slot0 & ~hit) : '0;
        note_req = note_valid ? (4'b0001 << note_lane) : '0;
    end

    always_comb begin
        lane_nxt = lane;
        for (int unsigned l = 0; l < 4; l++) begin
            if (shift)
                lane_nxt[l] = {pending[l], lane[l][15:1]};
            else if (hit[l])
                lane_nxt[l][0] = 1'b0;
        end
        pending_nxt = shift ? note_req : (pending | note_req);
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            vsync_q     <= 1'b0;
            frame_cnt   <= '0;
            lane        <= '0;
            pending     <= '0;
            btn_s1      <= '0;
            btn_s2      <= '0;
            btn_prev    <= '0;
            score       <= '0;
            miss_cnt    <= '0;
            scroll_tick <= 1'b0;
        end else begin
            vsync_q  <= vsync_in;
            btn_s1   <= btn;
            btn_s2   <= btn_s1;
            btn_prev <= btn_s2;
            if (frame_start)
                frame_cnt <= (frame_cnt == DIV_LAST) ? '0 : frame_cnt + 4'd1;
            lane        <= lane_nxt;
            pending     <= pending_nxt;
            score       <= sat_add(score, popcnt4(hit));
            miss_cnt    <= sat_add(miss_cnt, popcnt4(miss));
            scroll_tick <= shift;
        end
    end

    logic        in_lanes;
    logic [1:0]  lane_idx;
    logic [3:0]  slot_idx;
    logic        note_on;
    logic        hitbar_on;
    logic        boundary_on;
    logic [11:0] pix;

    always_comb begin
        in_lanes = (x_crd >= X0) && (x_crd < X4);
        if (x_crd < X1)      lane_idx = 2'd0;
        else if (x_crd < X2) lane_idx = 2'd1;
        else if (x_crd < X3) lane_idx = 2'd2;
        else                 lane_idx = 2'd3;
        // Row from the upper y bits; slot 15 is drawn at the top of the screen.
        slot_idx    = 4'd15 - 4'(y_crd >> SLOT_SHIFT);
        note_on     = in_lanes && (y_crd < NOTE_Y_END) && lane[lane_idx][slot_idx];
        hitbar_on   = in_lanes && (y_crd >= HB_Y0) && (y_crd < HB_Y1);
        boundary_on = (x_crd == X0) || (x_crd == X1) || (x_crd == X2) ||
                      (x_crd == X3) || (x_crd == X4);
        if (blank_in)         pix = 12'h000;
        else if (note_on)     pix = lane_colour(lane_idx);
        else if (hitbar_on)   pix = btn_s2[lane_idx] ? lane_colour(lane_idx) : 12'h888;
        else if (boundary_on) pix = 12'h444;
        else                  pix = 12'h000;
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) rgb <= '0;
        else     rgb <= pix;
    end

endmodule

// File: tb/tb_note_lane_renderer.sv
// Directed bench for note_lane_renderer: scrolling, hit/miss scoring, pixel colours,
// counter saturation and asynchronous reset.
module tb_note_lane_renderer;

    logic        pixel_clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] x_crd = '0;
    logic [10:0] y_crd = '0;
    logic        blank_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic        note_valid = 1'b0;
    logic [1:0]  note_lane = '0;
    logic [3:0]  btn = '0;
    logic [11:0] rgb;
    logic [15:0] score;
    logic [15:0] miss_cnt;
    logic        scroll_tick;

    int checks = 0;
    int errors = 0;
    int ticks  = 0;

    note_lane_renderer #(
        .SCROLL_DIV(4),
        .LANE_X0(200),
        .LANE_W(100),
        .SLOT_H(32),
        .HITBAR_Y(544)
    ) dut (
        .pixel_clk(pixel_clk),
        .rst(rst),
        .x_crd(x_crd),
        .y_crd(y_crd),
        .blank_in(blank_in),
        .vsync_in(vsync_in),
        .note_valid(note_valid),
        .note_lane(note_lane),
        .btn(btn),
        .rgb(rgb),
        .score(score),
        .miss_cnt(miss_cnt),
        .scroll_tick(scroll_tick)
    );

    always #5 pixel_clk = ~pixel_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge pixel_clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(1);
        ticks = 0;
    endtask

    // One vsync falling edge; scroll_tick is sampled in the cycle after it.
    task automatic frame();
        vsync_in = 1'b1;
        step(1);
        vsync_in = 1'b0;
        step(1);
        ticks += int'(scroll_tick);
    endtask

    task automatic scroll(input int n);
        repeat (n) repeat (4) frame();
    endtask

    task automatic add_note(input int l);
        note_valid = 1'b1;
        note_lane  = 2'(l);
        step(1);
        note_valid = 1'b0;
    endtask

    task automatic pixel(input int x, input int y, input logic b);
        x_crd    = 11'(x);
        y_crd    = 11'(y);
        blank_in = b;
        step(1);
    endtask

    initial begin
        step(2);
        rst = 1'b0;
        step(1);
        check("reset_rgb",   32'(rgb), 32'h000);
        check("reset_score", 32'(score), 32'h0);
        check("reset_miss",  32'(miss_cnt), 32'h0);
        check("reset_tick",  32'(scroll_tick), 32'h0);

        // Lane-2 note scrolls in after exactly SCROLL_DIV frames.
        add_note(2);
        repeat (3) frame();
        check("t1_no_early_tick", ticks, 0);
        frame();
        check("t1_one_tick", ticks, 1);
        step(1);
        check("t1_tick_one_cycle", 32'(scroll_tick), 32'h0);
        pixel(450, 10, 1'b0);
        check("t1_lane2_slot15", 32'(rgb), 32'hFF0);
        pixel(350, 10, 1'b0);
        check("t1_lane1_empty", 32'(rgb), 32'h000);

        // Unhit lane-0 note drops out after the 17th shift.
        do_reset();
        add_note(0);
        scroll(16);
        check("t2_no_miss_yet", 32'(miss_cnt), 32'h0);
        pixel(250, 490, 1'b0);
        check("t2_lane0_slot0", 32'(rgb), 32'h0F0);
        scroll(1);
        check("t2_miss", 32'(miss_cnt), 32'h1);
        check("t2_score", 32'(score), 32'h0);
        pixel(250, 490, 1'b0);
        check("t2_slot0_empty", 32'(rgb), 32'h000);

        // Lane-1 hit via a 3-cycle button pulse.
        do_reset();
        add_note(1);
        scroll(16);
        pixel(350, 490, 1'b0);
        check("t3_lane1_slot0", 32'(rgb), 32'hF00);
        btn   = 4'b0010;
        x_crd = 11'd350;
        y_crd = 11'd550;
        step(3);
        check("t3_hitbar_lit", 32'(rgb), 32'hF00);
        btn = 4'b0000;
        step(3);
        check("t3_hitbar_idle", 32'(rgb), 32'h888);
        check("t3_score", 32'(score), 32'h1);
        pixel(350, 490, 1'b0);
        check("t3_slot0_cleared", 32'(rgb), 32'h000);
        scroll(1);
        check("t3_no_miss", 32'(miss_cnt), 32'h0);

        // Lane-3 hit edge coincides with the shift that drops the note.
        do_reset();
        add_note(3);
        scroll(16);
        pixel(550, 490, 1'b0);
        check("t4_lane3_slot0", 32'(rgb), 32'h00F);
        repeat (3) frame();
        btn      = 4'b1000;
        vsync_in = 1'b1;
        step(2);
        vsync_in = 1'b0;
        step(1);
        check("t4_shift_tick", 32'(scroll_tick), 32'h1);
        check("t4_score", 32'(score), 32'h1);
        check("t4_no_miss", 32'(miss_cnt), 32'h0);
        btn = 4'b0000;
        pixel(550, 490, 1'b0);
        check("t4_slot0_from_slot1", 32'(rgb), 32'h000);
        scroll(1);
        check("t4_still_no_miss", 32'(miss_cnt), 32'h0);

        // Colour priority and boundaries.
        do_reset();
        add_note(0);
        scroll(1);
        pixel(250, 10, 1'b1);
        check("t5_blank_note", 32'(rgb), 32'h000);
        pixel(250, 10, 1'b0);
        check("t5_note", 32'(rgb), 32'h0F0);
        pixel(200, 10, 1'b0);
        check("t5_note_over_boundary", 32'(rgb), 32'h0F0);
        pixel(200, 300, 1'b0);
        check("t5_boundary_200", 32'(rgb), 32'h444);
        pixel(250, 550, 1'b0);
        check("t5_hitbar_grey", 32'(rgb), 32'h888);
        pixel(600, 300, 1'b0);
        check("t5_boundary_600", 32'(rgb), 32'h444);
        pixel(601, 300, 1'b0);
        check("t5_background", 32'(rgb), 32'h000);

        // Two simultaneous hits from 16'hFFFE saturate.
        do_reset();
        add_note(0);
        add_note(2);
        scroll(16);
        btn = 4'b0101;
        force dut.score = 16'hFFFE;
        #1;
        release dut.score;
        step(4);
        check("t6_score_sat", 32'(score), 32'hFFFF);
        check("t6_no_miss", 32'(miss_cnt), 32'h0);
        btn = 4'b0000;
        step(3);

        // Asynchronous reset mid-line, then resume with frame_cnt = 0.
        pixel(200, 300, 1'b0);
        check("t7_pre_reset_rgb", 32'(rgb), 32'h444);
        #2;
        rst = 1'b1;
        #1;
        check("t7_async_rgb", 32'(rgb), 32'h000);
        check("t7_async_score", 32'(score), 32'h0);
        step(1);
        rst = 1'b0;
        step(1);
        ticks = 0;
        add_note(1);
        repeat (3) frame();
        check("t7_no_early_tick", ticks, 0);
        frame();
        check("t7_tick_after_four", ticks, 1);
        pixel(350, 10, 1'b0);
        check("t7_lane1_slot15", 32'(rgb), 32'hF00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
